// File: rtl/loader_pkg.sv
// Shared types for the ioctl-to-SDRAM download loader.
package loader_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WADDR_W = 23;
    localparam int unsigned BADDR_W = 25;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        waddr_t waddr;
        word_t  data;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of packed words; a push while full is accepted only
// when a pop happens in the same cycle.
module loader_fifo
    import loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  fifo_entry_t   i_din,
    input  logic          i_pop,
    output fifo_entry_t   o_head_c,
    output logic          o_full_c,
    output logic          o_empty_c,
    output logic [CW-1:0] o_count_nxt_c
);

    localparam int unsigned AW = CW - 1;

    fifo_entry_t   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty_c     = (r_cnt == '0);
    assign o_full_c      = (r_cnt == CW'(FIFO_DEPTH));
    assign w_pop_ok      = i_pop & ~o_empty_c;
    assign w_push_ok     = i_push & (~o_full_c | w_pop_ok);
    assign o_count_nxt_c = r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);
    assign o_head_c      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt <= o_count_nxt_c;
        end
    end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs the ioctl download byte stream into little-endian 32-bit words,
// buffers them and writes them to SDRAM over a level req / pulse ack handshake.
module ioctl_sdram_loader
    import loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter waddr_t      WORD_OFFSET = 23'h0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [BADDR_W-1:0] ioctl_addr,
    input  logic [BYTE_W-1:0]  ioctl_data,
    output waddr_t             sdram_addr,
    output word_t              sdram_data,
    output logic               sdram_we,
    output logic               sdram_req,
    input  logic               sdram_ack,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic             r_dl;
    logic [LANES-1:0] r_mask;
    word_t            r_word;
    waddr_t           r_waddr;

    logic [LANES-1:0] w_mask_nxt;
    logic [LANES-1:0] w_mask_cur;
    logic [LANES-1:0] w_mask_base;
    logic [LANES-1:0] w_mask_new;
    word_t            w_word_nxt;
    word_t            w_word_base;
    word_t            w_word_new;
    waddr_t           w_waddr_nxt;
    waddr_t           w_byte_waddr;
    logic [1:0]       w_lane;
    logic             w_dl_rise;
    logic             w_dl_fall;
    logic             w_push;
    fifo_entry_t      w_push_entry;

    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    fifo_entry_t      w_head;
    logic [CW-1:0]    w_cnt_nxt;

    drain_state_t     r_state;
    drain_state_t     w_state_nxt;
    logic             r_req;
    waddr_t           r_addr;
    word_t            r_data;
    logic             r_busy;
    logic             r_ovf;

    assign w_byte_waddr = ioctl_addr[BADDR_W-1:2];
    assign w_lane       = ioctl_addr[1:0];
    assign w_dl_rise    = ioctl_download & ~r_dl;
    assign w_dl_fall    = ~ioctl_download & r_dl;
    // A new download session never inherits a stale partial word.
    assign w_mask_cur   = w_dl_rise ? '0 : r_mask;

    // Packer: lane merge, full-word flush, discontinuity and end-of-download flush.
    always_comb begin
        w_mask_nxt   = r_mask;
        w_word_nxt   = r_word;
        w_waddr_nxt  = r_waddr;
        w_mask_base  = w_mask_cur;
        w_word_base  = (w_mask_cur == '0) ? '0 : r_word;
        w_mask_new   = '0;
        w_word_new   = '0;
        w_push       = 1'b0;
        w_push_entry = '0;

        if (w_dl_fall) begin
            if (r_mask != '0) begin
                w_push       = 1'b1;
                w_push_entry = '{waddr: r_waddr + WORD_OFFSET, data: r_word};
                w_mask_nxt   = '0;
                w_word_nxt   = '0;
            end
        end else if (ioctl_wr && ioctl_download) begin
            if ((w_mask_cur != '0) && (w_byte_waddr != r_waddr)) begin
                w_push       = 1'b1;
                w_push_entry = '{waddr: r_waddr + WORD_OFFSET, data: r_word};
                w_mask_base  = '0;
                w_word_base  = '0;
            end
            w_word_new                         = w_word_base;
            w_word_new[{w_lane, 3'b000} +: 8]  = ioctl_data;
            w_mask_new                         = w_mask_base | (LANES'(1) << w_lane);
            w_waddr_nxt                        = w_byte_waddr;
            // A single fresh byte can never complete a word, so both pushes never coincide.
            if (w_mask_new == '1) begin
                w_push       = 1'b1;
                w_push_entry = '{waddr: w_byte_waddr + WORD_OFFSET, data: w_word_new};
                w_mask_nxt   = '0;
                w_word_nxt   = '0;
            end else begin
                w_mask_nxt = w_mask_new;
                w_word_nxt = w_word_new;
            end
        end else if (w_dl_rise) begin
            w_mask_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl    <= 1'b0;
            r_mask  <= '0;
            r_word  <= '0;
            r_waddr <= '0;
        end else begin
            r_dl    <= ioctl_download;
            r_mask  <= w_mask_nxt;
            r_word  <= w_word_nxt;
            r_waddr <= w_waddr_nxt;
        end
    end

    loader_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_push        (w_push),
        .i_din         (w_push_entry),
        .i_pop         (w_pop),
        .o_head_c      (w_head),
        .o_full_c      (w_full),
        .o_empty_c     (w_empty),
        .o_count_nxt_c (w_cnt_nxt)
    );

    // Drain FSM: pop in IDLE, hold the request until acked.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == REQ);
            if (w_pop) begin
                r_addr <= w_head.waddr;
                r_data <= w_head.data;
            end
            r_busy <= (w_mask_nxt != '0) | (w_cnt_nxt != '0) | (w_state_nxt == REQ);
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign sdram_addr = r_addr;
    assign sdram_data = r_data;
    assign sdram_req  = r_req;
    assign sdram_we   = r_req;
    assign busy       = r_busy;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench: a byte-level model predicts SDRAM writes; responders ack
// requests and compare each accepted write against the expected queue.
module tb_ioctl_sdram_loader;
    import loader_pkg::*;

    typedef struct packed {
        logic [22:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr_a;
    logic        ioctl_wr_b;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [22:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        we_a, we_b, req_a, req_b, ack_a, ack_b;
    logic        busy_a, busy_b, ovf_a, ovf_b;

    int  n_checks;
    int  n_errors;
    wr_t exp_q[$];
    wr_t exp_q_b[$];
    int  hold_ack;
    int  ack_delay;
    bit  rand_delay;
    int  writes_a;

    logic [7:0] m_lane[4];
    logic [3:0] m_mask;
    int         m_waddr;

    ioctl_sdram_loader #(.FIFO_DEPTH(4), .WORD_OFFSET(23'h0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr_a), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .sdram_addr(addr_a), .sdram_data(data_a), .sdram_we(we_a),
        .sdram_req(req_a), .sdram_ack(ack_a), .busy(busy_a), .overflow(ovf_a)
    );

    ioctl_sdram_loader #(.FIFO_DEPTH(4), .WORD_OFFSET(23'h100000)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr_b), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .sdram_addr(addr_b), .sdram_data(data_b), .sdram_we(we_b),
        .sdram_req(req_b), .sdram_ack(ack_b), .busy(busy_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_mask = 4'h0;
        foreach (m_lane[i]) m_lane[i] = 8'h00;
    endfunction

    function automatic void m_emit();
        wr_t w;
        w.a = 23'(m_waddr);
        w.d = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        exp_q.push_back(w);
        m_clear();
    endfunction

    // Model of one downloaded byte: words are built from byte lanes, absent lanes stay zero.
    function automatic void m_byte(input logic [24:0] addr, input logic [7:0] data);
        int w;
        int lane;
        w    = int'(addr >> 2);
        lane = int'(addr[1:0]);
        if (m_mask != 4'h0 && w != m_waddr) m_emit();
        m_waddr      = w;
        m_lane[lane] = data;
        m_mask[lane] = 1'b1;
        if (m_mask == 4'hF) m_emit();
    endfunction

    task automatic send(input logic [24:0] addr, input logic [7:0] data, input int gap);
        @(negedge clk);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr_a = 1'b1;
        if (ioctl_download) m_byte(addr, data);
        @(negedge clk);
        ioctl_wr_a = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_b(input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr_b = 1'b1;
        @(negedge clk);
        ioctl_wr_b = 1'b0;
    endtask

    task automatic set_dl(input logic v);
        @(negedge clk);
        if (ioctl_download && !v && m_mask != 4'h0) m_emit();
        if (!ioctl_download && v) m_clear();
        ioctl_download = v;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy_a || exp_q.size() != 0) && t < 3000);
        check({name, "_timeout"}, 64'(t >= 3000), 64'(0));
        check({name, "_busy"}, 64'(busy_a), 64'(0));
        check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Responder A: acks after ack_delay cycles and scores the accepted write.
    initial begin : resp_a
        int          cnt;
        bit          seen;
        logic [22:0] a0;
        logic [31:0] d0;
        wr_t         e;
        cnt   = 0;
        seen  = 1'b0;
        ack_a = 1'b0;
        forever begin
            @(negedge clk);
            ack_a = 1'b0;
            if (req_a && reset_n) begin
                if (!seen) begin
                    a0   = addr_a;
                    d0   = data_a;
                    seen = 1'b1;
                end
                if (hold_ack == 0 && cnt >= ack_delay) begin
                    ack_a = 1'b1;
                    writes_a++;
                    check("req_stable", 64'({addr_a, data_a}), 64'({a0, d0}));
                    check("wr_we", 64'(we_a), 64'(1));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr_a, data_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(addr_a), 64'(e.a));
                        check("wr_data", 64'(data_a), 64'(e.d));
                    end
                    cnt  = 0;
                    seen = 1'b0;
                    if (rand_delay) ack_delay = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end else begin
                cnt  = 0;
                seen = 1'b0;
            end
        end
    end

    initial begin : resp_b
        int  cnt;
        wr_t e;
        cnt   = 0;
        ack_b = 1'b0;
        forever begin
            @(negedge clk);
            ack_b = 1'b0;
            if (req_b && reset_n) begin
                cnt++;
                if (cnt == 2) begin
                    ack_b = 1'b1;
                    cnt   = 0;
                    if (exp_q_b.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write_b: got addr %0h data %0h expected none", addr_b, data_b);
                    end else begin
                        e = exp_q_b.pop_front();
                        check("wr_addr_b", 64'(addr_b), 64'(e.a));
                        check("wr_data_b", 64'(data_b), 64'(e.d));
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : stim
        int          t;
        int          w0;
        int unsigned cur;
        int unsigned r;
        wr_t         eb;
        n_checks       = 0;
        n_errors       = 0;
        hold_ack       = 0;
        ack_delay      = 1;
        rand_delay     = 1'b0;
        writes_a       = 0;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr_a     = 1'b0;
        ioctl_wr_b     = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        m_waddr        = 0;
        m_clear();
        #12;
        check("rst_outs_a", 64'({addr_a, data_a, we_a, req_a, busy_a, ovf_a}), 64'(0));
        check("rst_outs_b", 64'({we_b, req_b, busy_b, ovf_b}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Full aligned word, ack three cycles after request.
        ack_delay = 3;
        set_dl(1'b1);
        send(25'h0, 8'h11, 0);
        send(25'h1, 8'h22, 0);
        send(25'h2, 8'h33, 0);
        send(25'h3, 8'h44, 0);
        set_dl(1'b0);
        wait_idle("word0");

        // Partial word flushed by end of download.
        ack_delay = 1;
        set_dl(1'b1);
        send(25'h104, 8'hAA, 1);
        send(25'h105, 8'hBB, 1);
        set_dl(1'b0);
        wait_idle("partial");

        // Address discontinuity, then end-of-download flush.
        set_dl(1'b1);
        send(25'h2, 8'h55, 2);
        send(25'h10, 8'h66, 2);
        set_dl(1'b0);
        wait_idle("discont");

        // Lane rewrite overwrites without flushing.
        ack_delay = 0;
        set_dl(1'b1);
        send(25'h20, 8'h01, 0);
        send(25'h20, 8'h02, 0);
        send(25'h21, 8'h03, 0);
        send(25'h22, 8'h04, 0);
        send(25'h23, 8'h05, 0);
        set_dl(1'b0);
        wait_idle("rewrite");

        // Word offset on the second instance.
        eb.a = 23'h100000;
        eb.d = 32'hDDCCBBAA;
        exp_q_b.push_back(eb);
        set_dl(1'b1);
        send_b(25'h0, 8'hAA);
        send_b(25'h1, 8'hBB);
        send_b(25'h2, 8'hCC);
        send_b(25'h3, 8'hDD);
        set_dl(1'b0);
        t = 0;
        while ((busy_b || exp_q_b.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("offset_pending", 64'(exp_q_b.size()), 64'(0));
        check("offset_busy", 64'(busy_b), 64'(0));

        // Overflow: ack held low while 24 bytes stream back-to-back.
        hold_ack = 1;
        w0 = writes_a;
        set_dl(1'b1);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            ioctl_addr = 25'(32'h200 + i);
            ioctl_data = 8'(i + 1);
            ioctl_wr_a = 1'b1;
            m_byte(ioctl_addr, ioctl_data);
        end
        @(negedge clk);
        ioctl_wr_a = 1'b0;
        repeat (3) @(negedge clk);
        check("overflow_set", 64'(ovf_a), 64'(1));
        check("overflow_req_held", 64'(req_a), 64'(1));
        // Capacity is FIFO_DEPTH words plus one in flight; the sixth word is lost.
        void'(exp_q.pop_back());
        set_dl(1'b0);
        hold_ack = 0;
        wait_idle("overflow");
        check("overflow_writes", 64'(writes_a - w0), 64'(5));
        check("overflow_sticky", 64'(ovf_a), 64'(1));

        // Reset while a request is outstanding.
        hold_ack = 1;
        set_dl(1'b1);
        send(25'h300, 8'h9A, 0);
        send(25'h301, 8'h9B, 0);
        send(25'h302, 8'h9C, 0);
        send(25'h303, 8'h9D, 0);
        t = 0;
        while (!req_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_req_up", 64'(req_a), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_req", 64'({req_a, we_a}), 64'(0));
        check("rst_async_flags", 64'({busy_a, ovf_a}), 64'(0));
        exp_q.delete();
        m_clear();
        w0 = writes_a;
        @(negedge clk);
        reset_n  = 1'b1;
        hold_ack = 0;
        set_dl(1'b0);
        repeat (20) @(negedge clk);
        check("rst_no_write", 64'(writes_a - w0), 64'(0));
        check("rst_idle", 64'({busy_a, req_a}), 64'(0));

        // Randomised download with jumps, lane rewrites and session restarts.
        rand_delay = 1'b1;
        cur = $urandom_range(0, 32'h1FF_FF00);
        set_dl(1'b1);
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cur = $urandom_range(0, 32'h1FF_FF00);
            end else if (r < 14) begin
                cur = cur;
            end else if (r < 17) begin
                set_dl(1'b0);
                set_dl(1'b1);
            end else begin
                cur = cur + 1;
            end
            send(25'(cur), 8'($urandom), 8);
        end
        set_dl(1'b0);
        wait_idle("random");
        check("random_no_overflow", 64'(ovf_a), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Download-path stage between the HPS ioctl byte stream and the SDRAM controller's 32-bit request port.
- Packs the ROM bytes streamed during `ioctl_download` into little-endian 32-bit words.
- Buffers the packed words in a small FIFO and issues SDRAM writes using the req/ack handshake.
- Absorbs SDRAM latency, because ioctl has no back-pressure; the game core is held in reset during download, so the loader owns the SDRAM port while it is busy.

Parameters:
- FIFO_DEPTH, 4, number of packed words buffered (power of two, ≥2).
- WORD_OFFSET, 23'h0, added to every computed word address (mod 2^23).

Ports:
- clk  in  1  system clock (48 MHz).
- reset_n  in  1  reset, asynchronous assert, active-low.
- ioctl_download  in  1  high for the whole ROM download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_data  in  8  byte data.
- sdram_addr  out  23  word address.
- sdram_data  out  32  write data.
- sdram_we  out  1  write enable; 1 whenever `sdram_req` is high.
- sdram_req  out  1  request, level.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- busy  out  1  high while the packer is holding bytes, the FIFO is non-empty, or a request is outstanding.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset values (async, reset_n=0):
  - all outputs 0;
  - byte mask 0; FIFO empty; FSM in IDLE.
  - Reset mid-request drops `sdram_req` immediately; the in-flight word is discarded.
- Packer:
  - Holds `cur_waddr` (= `ioctl_addr[24:2]`), a 32-bit word register and a 4-bit byte mask.
  - On `ioctl_wr` with `ioctl_download=1`: byte lane `ioctl_addr[1:0]` is written (lane 0 = bits 7:0) and its mask bit is set.
  - Flush: when the mask becomes 4'hF, the word is pushed to the FIFO in the same cycle. Latency: 4th byte strobe to FIFO entry = 1 clk.
  - Address discontinuity: a byte whose word address ≠ `cur_waddr` while the mask is ≠0 pushes the partial word first. The new byte starts a fresh word in the same cycle.
  - A byte rewritten to an already-set lane overwrites the lane; no flush.
  - Falling edge of `ioctl_download` with mask ≠0 pushes the partial word.
  - Missing lanes in any partial word are zero-filled.
  - `ioctl_wr` while `ioctl_download=0` is ignored.
- FIFO entry: `{waddr + WORD_OFFSET, data}`. A push when full sets `overflow` (cleared only by reset) and the word is discarded. A push and a pop in the same cycle when full is legal.
- Drain FSM:
  - IDLE: FIFO non-empty → pop the head into the output registers, assert `sdram_req`/`sdram_we`, go to REQ (head-to-req latency 1 clk).
  - REQ: `sdram_addr`/`sdram_data` stay stable until `sdram_ack`. On ack, `sdram_req` drops the next cycle and the FSM returns to IDLE. Minimum 1 idle cycle between requests.
  - `sdram_ack` in IDLE is ignored.
- `busy` falls the cycle after the final ack, once the FIFO is empty and the mask is 0.
- Rising edge of `ioctl_download` clears the mask; it does not clear `overflow`.
- Widths: all address arithmetic is 23-bit modulo; addresses ≥ 2^25 bytes are not possible.

Decomposition:
- Shared package `loader_pkg`:
  - `word_t` (logic [31:0]), `waddr_t` (logic [22:0]);
  - `fifo_entry_t` struct {`waddr_t`, `word_t`};
  - drain state enum {IDLE, REQ}.
- Sub-module `loader_fifo`: synchronous FIFO parameterised by FIFO_DEPTH, entry type `fifo_entry_t`, ports push/pop/full/empty, async active-low reset.

Test Plan:
- Bytes 11,22,33,44 at addr 0..3, `sdram_ack` 3 clk after req → one write `sdram_addr=0`, `sdram_data=32'h44332211`, then `busy=0`.
- Bytes AA,BB at addr 0x104,0x105, then download falls → write `sdram_addr=0x41`, `sdram_data=32'h0000BBAA`.
- Byte 55 at addr 2, then byte 66 at addr 0x10 → writes {0x0, 32'h00550000} then, on download end, {0x4, 32'h00000066}, in order.
- Hold `sdram_ack` low and stream 24 bytes back-to-back → first 5 words accepted (4 FIFO + 1 in flight), `overflow=1`; releasing ack drains exactly 5 writes.
- WORD_OFFSET=23'h100000, bytes at addr 0..3 → `sdram_addr=23'h100000`.
- Assert `reset_n=0` while `sdram_req=1` → `sdram_req=0` asynchronously; after release, no write occurs and `busy=0`.
